// File: rtl/tm1638_serial_xfer.sv
// tm1638_serial_xfer: bit-serial word transfer engine for the TM1638 CLK/DIO
// interface, clocked by the 500 kHz driver clock. One word per start, either
// written to the device or read back from it (key-scan bytes). STB is owned
// by the command sequencer above this block.
//
// Build option: define TM1638_SER_MSB_FIRST_EN to shift MSB first. Default
// (undefined) is LSB first, the TM1638 native order. Timing is identical.
module tm1638_serial_xfer #(
  parameter int DATA_W      = 8,
  parameter int TURN_CYCLES = 1
) (
  input  logic              drvclk,
  input  logic              reset,
  input  logic              start,
  input  logic              rw,
  input  logic [DATA_W-1:0] wdata,
  output logic [DATA_W-1:0] rdata,
  output logic              busy,
  output logic              done,
  output logic              dev_clk,
  output logic              dev_dout,
  output logic              dev_oe,
  input  logic              dev_din
);

  localparam int CNT_W = 5;
  localparam int IDX_W = (DATA_W > 1) ? $clog2(DATA_W) : 1;
  localparam logic [CNT_W-1:0] LAST_CNT  = CNT_W'(DATA_W);
  localparam logic [3:0]       TURN_LOAD = 4'(TURN_CYCLES);

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    TURN  = 2'd1,
    SHIFT = 2'd2
  } state_t;

  state_t            state_r, state_s;
  logic [CNT_W-1:0]  cnt_r, cnt_s;
  logic [3:0]        turn_r, turn_s;
  logic [DATA_W-1:0] tx_r, tx_s;
  logic [DATA_W-1:0] rx_r, rx_s;
  logic [DATA_W-1:0] rdata_s;
  logic              rw_r, rw_s;
  logic              clk_s, dout_s, oe_s, done_s;

  // Map the running bit number onto the word index for the chosen bit order.
  function automatic logic [IDX_W-1:0] bit_idx(input logic [CNT_W-1:0] n);
`ifdef TM1638_SER_MSB_FIRST_EN
    bit_idx = IDX_W'(LAST_CNT - CNT_W'(1) - n);
`else
    bit_idx = IDX_W'(n);
`endif
  endfunction

  // State register.
  always_ff @(posedge drvclk or posedge reset) begin
    if (reset) begin
      state_r <= IDLE;
    end else begin
      state_r <= state_s;
    end
  end

  // Next-state decode: IDLE -> (TURN) -> SHIFT -> IDLE.
  always_comb begin
    state_s = state_r;
    case (state_r)
      IDLE: begin
        if (start) begin
          if (rw && (TURN_CYCLES > 0)) begin
            state_s = TURN;
          end else begin
            state_s = SHIFT;
          end
        end else begin
          state_s = IDLE;
        end
      end
      TURN: begin
        if (turn_r <= 4'd1) begin
          state_s = SHIFT;
        end else begin
          state_s = TURN;
        end
      end
      SHIFT: begin
        if (dev_clk && (cnt_r == LAST_CNT)) begin
          state_s = IDLE;
        end else begin
          state_s = SHIFT;
        end
      end
      default: state_s = IDLE;
    endcase
  end

  // Next values of the datapath and of the registered pin outputs.
  always_comb begin
    cnt_s   = cnt_r;
    turn_s  = turn_r;
    tx_s    = tx_r;
    rx_s    = rx_r;
    rw_s    = rw_r;
    rdata_s = rdata;
    clk_s   = dev_clk;
    dout_s  = dev_dout;
    oe_s    = dev_oe;
    done_s  = 1'b0;
    case (state_r)
      IDLE: begin
        if (start) begin
          tx_s  = wdata;
          rw_s  = rw;
          cnt_s = '0;
          if (!rw) begin
            clk_s  = 1'b0;
            dout_s = wdata[bit_idx(CNT_W'(0))];
          end else if (TURN_CYCLES > 0) begin
            // Release DIO and hold CLK high so the device can take over.
            oe_s   = 1'b0;
            dout_s = 1'b1;
            turn_s = TURN_LOAD;
          end else begin
            oe_s   = 1'b0;
            dout_s = 1'b1;
            clk_s  = 1'b0;
          end
        end else begin
          cnt_s = cnt_r;
        end
      end
      TURN: begin
        if (turn_r <= 4'd1) begin
          clk_s  = 1'b0;
          turn_s = 4'd0;
        end else begin
          turn_s = turn_r - 4'd1;
        end
      end
      SHIFT: begin
        if (!dev_clk) begin
          // Rising CLK: the device samples DIO here, and so do we on a read.
          clk_s = 1'b1;
          cnt_s = cnt_r + CNT_W'(1);
          if (rw_r) begin
            rx_s[bit_idx(cnt_r)] = dev_din;
          end else begin
            rx_s = rx_r;
          end
        end else if (cnt_r == LAST_CNT) begin
          dout_s = 1'b1;
          oe_s   = 1'b1;
          done_s = 1'b1;
          if (rw_r) begin
            rdata_s = rx_r;
          end else begin
            rdata_s = rdata;
          end
        end else begin
          clk_s = 1'b0;
          if (!rw_r) begin
            dout_s = tx_r[bit_idx(cnt_r)];
          end else begin
            dout_s = 1'b1;
          end
        end
      end
      default: begin
        clk_s  = 1'b1;
        dout_s = 1'b1;
        oe_s   = 1'b1;
      end
    endcase
  end

  // Datapath and output registers; busy tracks the state being entered.
  always_ff @(posedge drvclk or posedge reset) begin
    if (reset) begin
      cnt_r    <= '0;
      turn_r   <= 4'd0;
      tx_r     <= '0;
      rx_r     <= '0;
      rw_r     <= 1'b0;
      rdata    <= '0;
      dev_clk  <= 1'b1;
      dev_dout <= 1'b1;
      dev_oe   <= 1'b1;
      done     <= 1'b0;
      busy     <= 1'b0;
    end else begin
      cnt_r    <= cnt_s;
      turn_r   <= turn_s;
      tx_r     <= tx_s;
      rx_r     <= rx_s;
      rw_r     <= rw_s;
      rdata    <= rdata_s;
      dev_clk  <= clk_s;
      dev_dout <= dout_s;
      dev_oe   <= oe_s;
      done     <= done_s;
      busy     <= (state_s != IDLE);
    end
  end

endmodule

// File: tb/tb_tm1638_serial_xfer.sv
// Scoreboard bench for tm1638_serial_xfer: stimulus pushes expected words,
// a monitor reassembles the DIO bit stream and pops/compares on done.
module tb_tm1638_serial_xfer;

`ifdef TM1638_SER_MSB_FIRST_EN
  localparam int DW = 16;
`else
  localparam int DW = 8;
`endif
  localparam int TURN = 1;
  localparam int MASK = (1 << DW) - 1;

  logic          drvclk = 1'b0;
  logic          reset  = 1'b1;
  logic          start  = 1'b0;
  logic          rw     = 1'b0;
  logic [DW-1:0] wdata  = '0;
  logic [DW-1:0] rdata;
  logic          busy, done, dev_clk, dev_dout, dev_oe;
  logic          dev_din = 1'b1;

  tm1638_serial_xfer #(.DATA_W(DW), .TURN_CYCLES(TURN)) dut (
    .drvclk(drvclk), .reset(reset), .start(start), .rw(rw), .wdata(wdata),
    .rdata(rdata), .busy(busy), .done(done), .dev_clk(dev_clk),
    .dev_dout(dev_dout), .dev_oe(dev_oe), .dev_din(dev_din)
  );

  always #5 drvclk = ~drvclk;

  typedef struct {
    bit rw;
    int word;
  } exp_t;

  exp_t          expq[$];
  int            checks   = 0;
  int            failures = 0;
  logic [DW-1:0] dev_word = '0;
  int            dev_bit  = 0;

  task automatic chk(input string nm, input int act, input int req);
    checks++;
    if (act != req) begin
      failures++;
      $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", nm, act, req, $time);
    end
  endtask

  // Device model: presents the next bit after each CLK fall while DIO is released.
  always @(negedge dev_clk or posedge dev_oe) begin
    if (dev_oe) begin
      dev_bit = 0;
    end else begin
      if (dev_bit < DW) begin
`ifdef TM1638_SER_MSB_FIRST_EN
        dev_din = dev_word[DW-1-dev_bit];
`else
        dev_din = dev_word[dev_bit];
`endif
      end
      dev_bit++;
    end
  end

  // Monitor: collect bits and cycle counts, compare against the scoreboard on done.
  int busy_cnt = 0, oe_lo_cnt = 0, dout_bad = 0, last_rd = 0;
  bit prev_clk = 1'b1, prev_done = 1'b0;
  bit bits[$];
  always @(negedge drvclk) begin
    exp_t e;
    int   w;
    if (reset) begin
      busy_cnt = 0; oe_lo_cnt = 0; dout_bad = 0; last_rd = 0;
      bits.delete(); prev_clk = 1'b1; prev_done = 1'b0;
    end else begin
      if (busy) busy_cnt++;
      if (!dev_oe) oe_lo_cnt++;
      if ((!dev_oe || !busy) && !dev_dout) dout_bad = 1;
      if (!prev_clk && dev_clk && dev_oe) bits.push_back(dev_dout);
      if (done) begin
        chk("done_single", int'(prev_done), 0);
        if (expq.size() == 0) begin
          chk("spurious_done", 1, 0);
        end else begin
          e = expq.pop_front();
          chk("busy_cycles", busy_cnt, e.rw ? 2*DW + TURN : 2*DW);
          chk("oe_low_cycles", oe_lo_cnt, e.rw ? 2*DW + TURN : 0);
          chk("dout_released_high", dout_bad, 0);
          if (e.rw) begin
            chk("rdata", int'(rdata), e.word);
            last_rd = e.word;
          end else begin
            w = 0;
            for (int i = 0; i < bits.size(); i++) begin
`ifdef TM1638_SER_MSB_FIRST_EN
              if (bits[i] && i < DW) w |= 1 << (DW - 1 - i);
`else
              if (bits[i] && i < DW) w |= 1 << i;
`endif
            end
            chk("write_bit_count", bits.size(), DW);
            chk("write_word", w, e.word);
            chk("rdata_hold", int'(rdata), last_rd);
          end
        end
        busy_cnt = 0; oe_lo_cnt = 0; dout_bad = 0; bits.delete();
      end
      prev_clk  = dev_clk;
      prev_done = done;
    end
  end

  // Present one request for one clock edge, then scramble the inputs.
  task automatic start_xfer(input bit r, input int w);
    exp_t e;
    e.rw = r;
    e.word = w & MASK;
    if (r) dev_word = DW'(e.word);
    rw = r;
    wdata = DW'(e.word);
    start = 1'b1;
    expq.push_back(e);
    @(posedge drvclk); #1;
    start = 1'b0;
    wdata = DW'($urandom);
    rw = 1'($urandom);
  endtask

  task automatic wait_done();
    int n;
    n = 0;
    @(negedge drvclk);
    while (!done && n < 400) begin
      @(negedge drvclk);
      n++;
    end
    if (!done) chk("done_timeout", 0, 1);
  endtask

  initial begin
    exp_t e;
    repeat (2) @(negedge drvclk);
    chk("rst_dev_clk", int'(dev_clk), 1);
    chk("rst_dev_dout", int'(dev_dout), 1);
    chk("rst_dev_oe", int'(dev_oe), 1);
    chk("rst_busy", int'(busy), 0);
    chk("rst_done", int'(done), 0);
    chk("rst_rdata", int'(rdata), 0);
    reset = 1'b0;
    repeat (2) @(negedge drvclk);

    // Directed write (0x1234 in the 16-bit MSB-first build).
    start_xfer(1'b0, (DW == 16) ? 32'h1234 : 32'hA5);
    wait_done();
    repeat (2) @(negedge drvclk);

    // Directed read then a write that must leave rdata alone.
    start_xfer(1'b1, 32'h3C);
    wait_done();
    start_xfer(1'b0, 32'h5A);
    wait_done();
    repeat (1) @(negedge drvclk);

    // start held high across two words: second accepted in the done cycle.
    rw = 1'b0;
    wdata = DW'(32'h01);
    start = 1'b1;
    e.rw = 1'b0; e.word = 32'h01; expq.push_back(e);
    e.rw = 1'b0; e.word = 32'h80; expq.push_back(e);
    @(posedge drvclk); #1;
    wdata = DW'(32'h80);
    wait_done();
    chk("gap_clk_high", int'(dev_clk), 1);
    @(posedge drvclk); #1;
    start = 1'b0;
    @(negedge drvclk);
    chk("b2b_busy", int'(busy), 1);
    chk("b2b_clk_low", int'(dev_clk), 0);
    wait_done();

    // start while busy, with new inputs, must be ignored.
    start_xfer(1'b0, 32'hC3);
    repeat (2) @(posedge drvclk); #1;
    start = 1'b1;
    wdata = '0;
    rw = 1'($urandom);
    @(posedge drvclk); #1;
    start = 1'b0;
    wait_done();
    repeat (40) @(negedge drvclk);

    // Randomised mix of reads and writes with 0..2 idle cycles between them.
    for (int i = 0; i < 24; i++) begin
      repeat ($urandom_range(0, 2)) @(negedge drvclk);
      start_xfer(1'($urandom_range(0, 1)), int'($urandom));
    end_loop: wait_done();
    end

    // Make rdata nonzero, then abort a write with an asynchronous reset.
    start_xfer(1'b1, 32'h96);
    wait_done();
    start_xfer(1'b0, 32'hFF);
    repeat (4) @(posedge drvclk);
    #2;
    reset = 1'b1;
    #1;
    chk("abort_dev_clk", int'(dev_clk), 1);
    chk("abort_dev_dout", int'(dev_dout), 1);
    chk("abort_dev_oe", int'(dev_oe), 1);
    chk("abort_busy", int'(busy), 0);
    chk("abort_done", int'(done), 0);
    expq.delete();
    repeat (2) @(negedge drvclk);
    reset = 1'b0;
    chk("abort_rdata", int'(rdata), 0);
    repeat (30) @(negedge drvclk);

    // Engine still works after the abort.
    start_xfer(1'b1, int'($urandom));
    wait_done();
    start_xfer(1'b0, int'($urandom));
    wait_done();
    repeat (5) @(negedge drvclk);
    chk("scoreboard_empty", expq.size(), 0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/tm1638_serial_xfer.md
Name: tm1638_serial_xfer

Overview:
Parametrised bit-serial transfer engine for the TM1638 CLK/DIO interface, clocked by the 500 kHz driver clock.
- Supports both write (controller to device) and read (device to controller, e.g. the key-scan bytes).
- Configurable word width and read turnaround time.
- Data is latched at start; a one-cycle done pulse marks completion.
- Sits below the TM1638 command sequencer, which owns STB and issues one word per start.

Parameters:
DATA_W, 8, bits per transfer (1..16)
TURN_CYCLES, 1, drvclk cycles with DIO released and CLK high before the first read bit (0..15)

Ports:
drvclk  in  1  driver clock, 500 kHz
reset  in  1  asynchronous, active-high reset
start  in  1  request a transfer; sampled only in IDLE
rw  in  1  0 = write, 1 = read; latched with start
wdata  in  DATA_W  write word; latched with start
rdata  out  DATA_W  last completed read word
busy  out  1  high while a transfer is in progress
done  out  1  one-cycle pulse on completion
dev_clk  out  1  TM1638 CLK
dev_dout  out  1  DIO drive value
dev_oe  out  1  DIO output enable (1 = controller drives DIO)
dev_din  in  1  DIO input, already synchronised by top level

Behaviour:
- Clock and reset: reset is asynchronous, active-high; clock is drvclk.
- Reset values: state = IDLE, dev_clk = 1, dev_dout = 1, dev_oe = 1, busy = 0, done = 0, rdata = 0, bit counter = 0, turn counter = 0, shift registers = 0.
- States are IDLE, TURN and SHIFT.
- busy = (state != IDLE).
- done is registered: high for exactly the cycle after the edge that returns the block to IDLE.

IDLE:
- When start = 1: latch wdata and rw, clear the bit counter.
- rw = 0: go to SHIFT, dev_clk <= 0, dev_dout <= first bit.
- rw = 1 and TURN_CYCLES > 0: go to TURN, dev_oe <= 0, dev_dout <= 1, dev_clk stays 1, load the turn counter.
- rw = 1 and TURN_CYCLES = 0: go to SHIFT, dev_oe <= 0, dev_clk <= 0.

TURN:
- Count down TURN_CYCLES cycles, then go to SHIFT with dev_clk <= 0.

SHIFT:
- Each bit takes 2 cycles (CLK low, then CLK high).
- When dev_clk = 0: dev_clk <= 1, counter + 1.
  - On a read, the same edge captures dev_din into the receive shift register at the current bit index.
- When dev_clk = 1 and counter < DATA_W: dev_clk <= 0; on a write, dev_dout <= next bit.
- When dev_clk = 1 and counter = DATA_W: go to IDLE, dev_dout <= 1, dev_oe <= 1, done <= 1.
  - On a read, rdata <= receive register.

Timing:
- Write: busy for 2*DATA_W cycles from the start edge.
- Read: busy for 2*DATA_W + TURN_CYCLES cycles from the start edge.
- Bit order is LSB first, unless the optional feature below is compiled in.

Stability and boundary rules:
- rdata changes only on the done edge of a read; writes never alter it.
- start while busy is ignored; wdata and rw changes mid-transfer have no effect.
- start in the done cycle is accepted (state is already IDLE), so back-to-back transfers are allowed.
- Minimum CLK-high gap between words is 1 cycle.
- dev_dout is 1 whenever dev_oe = 0 or the block is idle.
- Reset mid-transfer aborts immediately to reset values: no done pulse, rdata unchanged from its reset value of 0.

Optional Feature:
TM1638_SER_MSB_FIRST_EN
- Defined: transmit and receive MSB first, bit index DATA_W-1 down to 0.
- Undefined: LSB first, the TM1638 native order. All timing is identical in both builds.

Test Plan:
1. Write with DATA_W = 8, wdata = 0xA5 -> dev_dout at the 8 CLK rising edges = 1,0,1,0,0,1,0,1; busy high 16 cycles; done a single pulse; dev_dout = 1 afterwards; dev_oe stays 1.
2. Read with TURN_CYCLES = 1, device model driving 0x3C LSB first on CLK falling edges -> dev_oe low for 17 cycles; rdata = 0x3C at done; rdata unchanged by a following write.
3. Reset asserted 5 cycles into a write of 0xFF -> dev_clk = 1, dev_dout = 1, dev_oe = 1, busy = 0 immediately (asynchronous); no done pulse.
4. start held high continuously with wdata 0x01 then 0x80 -> second transfer begins in the done cycle; CLK high gap of exactly 1 cycle; both words are correct on DIO.
5. start pulsed at cycle 3 of a busy write, with wdata changed to 0x00 -> ignored; the original word completes; exactly one done pulse.
6. DATA_W = 16 with TM1638_SER_MSB_FIRST_EN, write 0x1234 -> DIO bits 0001001000110100 in order; busy 32 cycles.
